serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor; successor to the team's fixed 4-bit ripple add/sub.
- Processes DIGIT bits per clock over WIDTH/DIGIT cycles, trading latency for a small carry chain.
- Valid/ready handshake on both sides; reports carry-out, signed overflow and zero flags.
- Sits between operand registers and the result bus in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and sub are valid.
- in_ready  output  1  block can accept an operation.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- sub  input  1  0 = x+y, 1 = x-y.
- out_valid  output  1  result valid; held until taken.
- out_ready  input  1  consumer takes the result.
- s  output  WIDTH  result.
- cout  output  1  carry out of MSB. For subtraction, 1 means no borrow (x >= y unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  s == 0, evaluated after saturation when enabled.

Behaviour:
- Synchronous reset: state IDLE; in_ready=1; out_valid=0; s=0; cout=0; ovf=0; zero=0; internal registers cleared.
- Reset during RUN or DONE aborts the operation. The result is discarded and never presented.
- N = WIDTH/DIGIT. A digit counter of width clog2(N), minimum 1, counts 0..N-1.
- States:
  - IDLE: in_ready=1. On the edge where in_valid=1, latch x, y^{WIDTH{sub}} and carry=sub, clear counter, go to RUN.
  - RUN: in_ready=0. Each edge adds digit[cnt] of A, digit[cnt] of B' and the carry. Writes the digit into the result register, updates carry and increments the counter, processing from LSB to MSB.
  - RUN exit: on the edge processing digit N-1, register cout (final carry) and ovf (carry into MSB XOR carry out of MSB), then go to DONE.
  - DONE: out_valid=1. s, cout, ovf and zero are stable. On the edge with out_ready=1, go to IDLE and drop out_valid.
  - DONE with out_ready=0: hold indefinitely.
- Latency: out_valid asserts N cycles after the accept cycle (4 at defaults).
- Throughput: one operation per N+2 cycles. There is no accept in the same cycle as the result handoff.
- in_valid while busy is ignored. The upstream must hold in_valid and operands until in_ready=1.
- Outputs s, cout, ovf and zero keep their last values outside DONE; only out_valid qualifies them.
- Arithmetic is modulo 2^WIDTH. Subtraction uses invert-plus-one through the carry-in; no separate negation.
- N=1 (DIGIT=WIDTH) is legal: a single RUN cycle.

Optional Feature:
- Macro SERIAL_ADD_SUB_SATURATE_EN.
- Defined: when ovf=1, s is clamped to the signed limit, 2^(WIDTH-1)-1 if the true result is positive, else -2^(WIDTH-1). The sign is taken from the MSB of A: on overflow both effective operands share that sign. ovf and cout still report the raw event. Clamping is applied on the final RUN edge, with no extra cycle.
- Undefined: s is the wrapped result.

Decomposition:
- Package serial_add_sub_pkg holds:
  - state typedef (IDLE, RUN, DONE);
  - default WIDTH/DIGIT constants;
  - a function computing N and the counter width.
- One sub-module, digit_add: combinational DIGIT-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout and c_msb_in (carry into the top bit, used for ovf).
  - Instantiated once, muxed by the counter.

Test Plan:
- Defaults, add 0x1234+0x0FF1 -> out_valid 4 cycles after accept; s=0x2225, cout=0, ovf=0, zero=0.
- Sub 0x0005-0x0007 -> s=0xFFFE, cout=0 (borrow), ovf=0. Then sub 0x0007-0x0007 -> s=0x0000, cout=1, zero=1.
- Signed overflow, add 0x7FFF+0x0001 -> ovf=1; s=0x8000 without macro, 0x7FFF with SATURATE_EN. Sub 0x8000-0x0001 -> ovf=1; s=0x7FFF without macro, 0x8000 with it.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and s stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle.
- Reset asserted on the second RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, outputs zero. No stale result ever appears.
- Parameter sweep, (WIDTH, DIGIT) = (8,1), (8,8), (32,4): 1000 random ops each against a reference model -> exact match on s, cout and ovf; latency = N.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg
//   Shared types and sizing helpers for the digit-serial adder/subtractor.
//   - state_t           : controller states (IDLE, RUN, DONE)
//   - DEF_WIDTH/DEF_DIGIT : default operand width and digit size
//   - num_digits()      : digits per operand, N = WIDTH/DIGIT
//   - cnt_width()       : digit counter width, clog2(N) with a floor of 1
package serial_add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DIGIT = 4;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   // A single-digit operation still needs a 1-bit counter to keep the
   // select logic well formed.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_add_sub_digit_add.sv
// digit_add
//   Combinational DIGIT-bit ripple-carry adder used once per clock by the
//   serial adder.
//   Ports:
//     a, b      DIGIT-bit addends
//     cin       carry in
//     sum       DIGIT-bit sum
//     cout      carry out of the top bit
//     c_msb_in  carry into the top bit (signed overflow = c_msb_in ^ cout)
module digit_add #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout     = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Digit-serial two's-complement adder/subtractor. Processes DIGIT bits per
//   clock, LSB digit first, over N = WIDTH/DIGIT cycles.
//   Ports:
//     clk, rst              rising-edge clock, synchronous active-high reset
//     in_valid / in_ready   operand handshake (x, y, sub)
//     x, y                  WIDTH-bit operands; sub=1 selects x-y
//     out_valid / out_ready result handshake; result held until taken
//     s                     WIDTH-bit result
//     cout                  carry out of MSB (for sub: 1 = no borrow)
//     ovf                   signed overflow
//     zero                  s == 0 (after clamping when enabled)
//   Build option:
//     SERIAL_ADD_SUB_SATURATE_EN  clamp s to the signed limit on overflow.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int            N    = num_digits(WIDTH, DIGIT);
   localparam int            CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, r_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] s_q;
   logic             cout_q, ovf_q, zero_q;

   logic [DIGIT-1:0] a_dig, b_dig, dsum;
   logic             dcout, dc_msb;
   logic [WIDTH-1:0] res_word, fin_word;
   logic             ovf_fin;
   logic             last_dig;

   // Operands are latched once; the counter selects which digit feeds the
   // single adder instance each cycle.
   always_comb begin
      a_dig = a_q[DIGIT*int'(cnt_q) +: DIGIT];
      b_dig = b_q[DIGIT*int'(cnt_q) +: DIGIT];
   end

   digit_add #(.DIGIT(DIGIT)) u_digit_add (
      .a        (a_dig),
      .b        (b_dig),
      .cin      (carry_q),
      .sum      (dsum),
      .cout     (dcout),
      .c_msb_in (dc_msb)
   );

   assign last_dig = (cnt_q == LAST);
   assign ovf_fin  = dc_msb ^ dcout;

   always_comb begin
      res_word = r_q;
      res_word[DIGIT*int'(cnt_q) +: DIGIT] = dsum;
      fin_word = res_word;
`ifdef SERIAL_ADD_SUB_SATURATE_EN
      // On overflow both effective operands carry A's sign, so A's MSB
      // tells which limit the true result ran past.
      if (ovf_fin) begin
         fin_word = (WIDTH'(1) << (WIDTH - 1));
         if (!a_q[WIDTH-1]) fin_word = ~fin_word;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_dig)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (in_valid) begin
               // Subtraction: invert B here, the +1 enters as carry-in.
               a_q     <= x;
               b_q     <= y ^ {WIDTH{sub}};
               carry_q <= sub;
               cnt_q   <= '0;
            end
            RUN: begin
               r_q     <= res_word;
               carry_q <= dcout;
               cnt_q   <= cnt_q + 1'b1;
               // Visible outputs update only once, so they never show a
               // partially built result.
               if (last_dig) begin
                  s_q    <= fin_word;
                  cout_q <= dcout;
                  ovf_q  <= ovf_fin;
                  zero_q <= (fin_word == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub
//   Directed checks of the default 16/4 configuration plus random sweeps of
//   the (8,1), (8,8) and (32,4) configurations against a reference model.
module tb_serial_add_sub;

   logic clk, rst;

   // default-configuration DUT
   logic        d_iv, d_ir, d_sub, d_ov, d_or, d_cout, d_ovf, d_zero;
   logic [15:0] d_x, d_y, d_s;

   // sweep DUTs: index 0=(8,1), 1=(8,8), 2=(32,4)
   logic [2:0]  w_iv, w_ir, w_sub, w_ov, w_or, w_cout, w_ovf, w_zero;
   logic [31:0] w_x, w_y;
   logic [7:0]  s0, s1;
   logic [31:0] s2;
   logic [31:0] w_s [3];

   int vectors = 0;
   int errors  = 0;

   assign w_s[0] = {24'b0, s0};
   assign w_s[1] = {24'b0, s1};
   assign w_s[2] = s2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .x(d_x), .y(d_y),
      .sub(d_sub), .out_valid(d_ov), .out_ready(d_or), .s(d_s), .cout(d_cout),
      .ovf(d_ovf), .zero(d_zero));

   serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
      .clk(clk), .rst(rst), .in_valid(w_iv[0]), .in_ready(w_ir[0]), .x(w_x[7:0]),
      .y(w_y[7:0]), .sub(w_sub[0]), .out_valid(w_ov[0]), .out_ready(w_or[0]),
      .s(s0), .cout(w_cout[0]), .ovf(w_ovf[0]), .zero(w_zero[0]));

   serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
      .clk(clk), .rst(rst), .in_valid(w_iv[1]), .in_ready(w_ir[1]), .x(w_x[7:0]),
      .y(w_y[7:0]), .sub(w_sub[1]), .out_valid(w_ov[1]), .out_ready(w_or[1]),
      .s(s1), .cout(w_cout[1]), .ovf(w_ovf[1]), .zero(w_zero[1]));

   serial_add_sub #(.WIDTH(32), .DIGIT(4)) u_w32d4 (
      .clk(clk), .rst(rst), .in_valid(w_iv[2]), .in_ready(w_ir[2]), .x(w_x),
      .y(w_y), .sub(w_sub[2]), .out_valid(w_ov[2]), .out_ready(w_or[2]),
      .s(s2), .cout(w_cout[2]), .ovf(w_ovf[2]), .zero(w_zero[2]));

   // Stimulus helper: present one op, wait for the accept edge, then count
   // edges until out_valid (bounded). Leaves the DUT in DONE.
   task automatic start_op(input logic [15:0] xa, input logic [15:0] yb,
                           input logic sb, output int lat);
      @(negedge clk);
      d_x = xa; d_y = yb; d_sub = sb; d_iv = 1'b1;
      @(posedge clk); #1;
      d_iv = 1'b0;
      lat = 0;
      while (!d_ov && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take_result();
      d_or = 1'b1;
      @(posedge clk); #1;
      d_or = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({d_ir, d_ov, d_cout, d_ovf, d_zero} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags got=%b want=10000", {d_ir, d_ov, d_cout, d_ovf, d_zero});
      end
      vectors++;
      if (d_s !== 16'h0000) begin
         errors++;
         $display("FAIL reset_s got=%h want=0000", d_s);
      end
      vectors++;
      if (w_ir !== 3'b111 || w_ov !== 3'b000) begin
         errors++;
         $display("FAIL reset_sweep got ir=%b ov=%b want 111/000", w_ir, w_ov);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      int lat;
      start_op(16'h1234, 16'h0FF1, 1'b0, lat);
      vectors++;
      if (lat !== 4) begin errors++; $display("FAIL add_latency got=%0d want=4", lat); end
      vectors++;
      if (d_s !== 16'h2225) begin errors++; $display("FAIL add_s got=%h want=2225", d_s); end
      vectors++;
      if ({d_cout, d_ovf, d_zero, d_ir} !== 4'b0000) begin
         errors++; $display("FAIL add_flags got=%b want=0000", {d_cout, d_ovf, d_zero, d_ir});
      end
      take_result();
      // carry out of MSB with a wrapped zero result
      start_op(16'hFFFF, 16'h0001, 1'b0, lat);
      vectors++;
      if ({d_s, d_cout, d_ovf, d_zero} !== {16'h0000, 3'b101}) begin
         errors++; $display("FAIL add_wrap got s=%h c/o/z=%b want 0000/101", d_s, {d_cout, d_ovf, d_zero});
      end
      take_result();
   endtask

   task automatic test_sub();
      int lat;
      start_op(16'h0005, 16'h0007, 1'b1, lat);
      vectors++;
      if ({d_s, d_cout, d_ovf, d_zero} !== {16'hFFFE, 3'b000}) begin
         errors++; $display("FAIL sub_borrow got s=%h c/o/z=%b want FFFE/000", d_s, {d_cout, d_ovf, d_zero});
      end
      take_result();
      vectors++;
      if ({d_ov, d_ir} !== 2'b01) begin
         errors++; $display("FAIL handoff_idle got ov/ir=%b want 01", {d_ov, d_ir});
      end
      start_op(16'h0007, 16'h0007, 1'b1, lat);
      vectors++;
      if ({d_s, d_cout, d_ovf, d_zero} !== {16'h0000, 3'b101}) begin
         errors++; $display("FAIL sub_equal got s=%h c/o/z=%b want 0000/101", d_s, {d_cout, d_ovf, d_zero});
      end
      take_result();
   endtask

   task automatic test_overflow();
      int lat;
      logic [15:0] e1, e2;
`ifdef SERIAL_ADD_SUB_SATURATE_EN
      e1 = 16'h7FFF; e2 = 16'h8000;
`else
      e1 = 16'h8000; e2 = 16'h7FFF;
`endif
      start_op(16'h7FFF, 16'h0001, 1'b0, lat);
      vectors++;
      if ({d_s, d_cout, d_ovf, d_zero} !== {e1, 3'b010}) begin
         errors++; $display("FAIL ovf_add got s=%h c/o/z=%b want %h/010", d_s, {d_cout, d_ovf, d_zero}, e1);
      end
      take_result();
      start_op(16'h8000, 16'h0001, 1'b1, lat);
      vectors++;
      if ({d_s, d_cout, d_ovf, d_zero} !== {e2, 3'b110}) begin
         errors++; $display("FAIL ovf_sub got s=%h c/o/z=%b want %h/110", d_s, {d_cout, d_ovf, d_zero}, e2);
      end
      take_result();
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(16'h00FF, 16'h0001, 1'b0, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         d_iv = 1'b1; d_x = 16'hAAAA; d_y = 16'h5555; d_sub = 1'b0;
         @(posedge clk); #1;
         vectors++;
         if ({d_ov, d_ir} !== 2'b10 || d_s !== 16'h0100) begin
            errors++;
            $display("FAIL hold_%0d got ov/ir=%b s=%h want 10/0100", i, {d_ov, d_ir}, d_s);
         end
      end
      d_iv = 1'b0;
      take_result();
      vectors++;
      if ({d_ov, d_ir} !== 2'b01) begin
         errors++; $display("FAIL release got ov/ir=%b want 01", {d_ov, d_ir});
      end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({d_ov, d_ir} !== 2'b01) begin
         errors++; $display("FAIL stale_accept got ov/ir=%b want 01", {d_ov, d_ir});
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      @(negedge clk);
      d_x = 16'h1111; d_y = 16'h2222; d_sub = 1'b0; d_iv = 1'b1;
      @(posedge clk); #1;      // accepted
      d_iv = 1'b0;
      @(posedge clk); #1;      // first RUN edge done, now in second RUN cycle
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if ({d_ir, d_ov, d_cout, d_ovf, d_zero} !== 5'b10000 || d_s !== 16'h0000) begin
         errors++;
         $display("FAIL abort_state got ir/ov/c/o/z=%b s=%h want 10000/0000",
                  {d_ir, d_ov, d_cout, d_ovf, d_zero}, d_s);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (d_ov) seen++;
      end
      vectors++;
      if (seen !== 0) begin errors++; $display("FAIL abort_stale got=%0d want=0", seen); end
   endtask

   task automatic test_sweep(input int k, input int w, input int n);
      longint unsigned mask, xa, yb, a, b, full, es, msb;
      logic sb, ec, eo;
      int lat;
      mask = (64'd1 << w) - 64'd1;
      msb  = 64'd1 << (w - 1);
      for (int op = 0; op < 1000; op++) begin
         case ($urandom_range(0, 7))
            0: xa = 0;  1: xa = mask;  2: xa = msb;  3: xa = msb - 1;
            default: xa = longint'($urandom) & mask;
         endcase
         case ($urandom_range(0, 7))
            0: yb = 0;  1: yb = mask;  2: yb = msb;  3: yb = 1;
            default: yb = longint'($urandom) & mask;
         endcase
         sb   = 1'($urandom_range(0, 1));
         a    = xa;
         b    = (sb ? ~yb : yb) & mask;
         full = a + b + (sb ? 64'd1 : 64'd0);
         es   = full & mask;
         ec   = ((full >> w) & 64'd1) != 0;
         eo   = (((a & msb) != 0) == ((b & msb) != 0)) && (((es & msb) != 0) != ((a & msb) != 0));
`ifdef SERIAL_ADD_SUB_SATURATE_EN
         if (eo) es = ((a & msb) != 0) ? msb : msb - 1;
`endif
         @(negedge clk);
         w_x = 32'(xa); w_y = 32'(yb); w_sub[k] = sb; w_iv[k] = 1'b1;
         vectors++;
         if (w_ir[k] !== 1'b1) begin errors++; $display("FAIL sw%0d_ready op%0d got=%b want=1", k, op, w_ir[k]); end
         @(posedge clk); #1;
         w_iv[k] = 1'b0;
         lat = 0;
         while (!w_ov[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
         end
         vectors++;
         if (lat !== n) begin errors++; $display("FAIL sw%0d_latency op%0d got=%0d want=%0d", k, op, lat, n); end
         vectors++;
         if (w_s[k] !== 32'(es) || w_cout[k] !== ec || w_ovf[k] !== eo || w_zero[k] !== (es == 0)) begin
            errors++;
            $display("FAIL sw%0d_result op%0d x=%h y=%h sub=%b got s=%h c=%b o=%b z=%b want s=%h c=%b o=%b z=%b",
                     k, op, xa, yb, sb, w_s[k], w_cout[k], w_ovf[k], w_zero[k], es, ec, eo, es == 0);
         end
         w_or[k] = 1'b1;
         @(posedge clk); #1;
         w_or[k] = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      d_iv = 1'b0; d_or = 1'b0; d_sub = 1'b0; d_x = '0; d_y = '0;
      w_iv = '0; w_or = '0; w_sub = '0; w_x = '0; w_y = '0;
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_backpressure();
      test_reset_abort();
      test_sweep(0, 8, 8);
      test_sweep(1, 8, 1);
      test_sweep(2, 32, 8);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
